ball_move_scheduler: RTL

- Sequences the `move` inputs of up to NUM_BALLS bouncing-ball engines sharing one VGA raster.
- Once per frame, at a fixed blanking position, it walks the balls in index order and issues at most one single-pixel-slot `move` pulse per ball.
- Each ball has a per-ball frame-period speed setting, plus global pause and single-step control.
- Sits between the VGA timing generator and the ball instances. A ball's neighbour scan for the whole visible frame is complete before that ball is told to move.

---
 rtl/ball_move_scheduler_if.sv | 28 ++
 rtl/ball_move_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ball_move_scheduler_if.sv
// Bundle of raster, control, configuration and move signals that pass
// between the timing/control side and the ball move scheduler.
interface ball_move_scheduler_if #(
  parameter int NUM_BALLS = 4,
  parameter int IDXW      = 3
);
  logic                 pixpulse;
  logic [9:0]           hcount;
  logic [9:0]           vcount;
  logic                 pause;
  logic                 step;
  logic                 cfg_we;
  logic [IDXW-1:0]      cfg_idx;
  logic [3:0]           cfg_period;
  logic [NUM_BALLS-1:0] move;
  logic                 frame_tick;
  logic                 busy;

  modport master (
    output pixpulse, hcount, vcount, pause, step, cfg_we, cfg_idx, cfg_period,
    input  move, frame_tick, busy
  );

  modport slave (
    input  pixpulse, hcount, vcount, pause, step, cfg_we, cfg_idx, cfg_period,
    output move, frame_tick, busy
  );
endinterface

// File: rtl/ball_move_scheduler.sv
// Once per frame, at a fixed blanking position, walks the balls in index
// order and issues at most one single-pixel-slot move pulse per ball.
// Each ball moves every period[i] frames; period 0 freezes the ball.
// Global pause suppresses frame processing, step forces one frame through.
module ball_move_scheduler #(
  parameter int NUM_BALLS      = 4,
  parameter int IDXW           = 3,
  parameter int TRIG_H         = 0,
  parameter int TRIG_V         = 480,
  parameter int DEFAULT_PERIOD = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ball_move_scheduler_if.slave bus
);

  localparam logic [9:0]      TRIG_H_L   = 10'(TRIG_H);
  localparam logic [9:0]      TRIG_V_L   = 10'(TRIG_V);
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_BALLS - 1);
  localparam logic [3:0]      DEF_PERIOD = 4'(DEFAULT_PERIOD);
  localparam logic [IDXW:0]   NUM_BALLS_L = (IDXW + 1)'(NUM_BALLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [NUM_BALLS-1:0] move_q, move_d;
  logic                 frame_tick_q, frame_tick_d;
  logic                 busy_q, busy_d;
  logic                 step_pending_q, step_pending_d;
  logic [3:0]           period_q [NUM_BALLS];
  logic [3:0]           period_d [NUM_BALLS];
  logic [3:0]           cnt_q    [NUM_BALLS];
  logic [3:0]           cnt_d    [NUM_BALLS];

  logic trigger;
  logic cfg_hit;

  // Next-state logic: sequencer walk, per-ball frame counters, step latch and
  // configuration writes (a write overrides the evaluation of the same ball).
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    move_d         = move_q;
    step_pending_d = step_pending_q;
    period_d       = period_q;
    cnt_d          = cnt_q;

    trigger = bus.pixpulse && (bus.hcount == TRIG_H_L) && (bus.vcount == TRIG_V_L);
    cfg_hit = bus.cfg_we && ({1'b0, bus.cfg_idx} < NUM_BALLS_L);

    frame_tick_d = trigger;

    if (bus.pixpulse) begin
      unique case (state_q)
        IDLE: begin
          if (trigger && (!bus.pause || step_pending_q)) begin
            state_d        = ISSUE;
            idx_d          = '0;
            step_pending_d = 1'b0;
          end
        end
        ISSUE: begin
          move_d = '0;
          for (int i = 0; i < NUM_BALLS; i++) begin
            if (idx_q == IDXW'(i)) begin
              if (period_q[i] != 4'd0) begin
                if (cnt_q[i] == period_q[i] - 4'd1) begin
                  cnt_d[i]  = 4'd0;
                  move_d[i] = 1'b1;
                end else begin
                  cnt_d[i] = cnt_q[i] + 4'd1;
                end
              end else begin
                cnt_d[i] = 4'd0;
              end
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
        DRAIN: begin
          move_d  = '0;
          state_d = IDLE;
        end
        default: begin
          move_d  = '0;
          state_d = IDLE;
        end
      endcase
    end

    if (bus.step) begin
      step_pending_d = 1'b1;
    end

    if (cfg_hit) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (bus.cfg_idx == IDXW'(i)) begin
          period_d[i] = bus.cfg_period;
          cnt_d[i]    = 4'd0;
          if (bus.pixpulse && (state_q == ISSUE) && (idx_q == IDXW'(i))) begin
            move_d[i] = 1'b0;
          end
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset clears the move lines immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      move_q         <= '0;
      frame_tick_q   <= 1'b0;
      busy_q         <= 1'b0;
      step_pending_q <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        period_q[i] <= DEF_PERIOD;
        cnt_q[i]    <= 4'd0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      move_q         <= move_d;
      frame_tick_q   <= frame_tick_d;
      busy_q         <= busy_d;
      step_pending_q <= step_pending_d;
      period_q       <= period_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.move       = move_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.busy       = busy_q;

endmodule
